// File: rtl/alu_issue.sv
// alu_issue: in-order issue stage that sits in front of a single ALU.
//   - 8 x DW register file. r0 always reads as zero. Writeback to a source
//     register is bypassed to the operand read in the same cycle.
//   - Scoreboard with one pending-write bit per register. It detects RAW
//     hazards on rs1/rs2 and WAW hazards on rd.
//   - One-entry registered operand bundle toward the ALU, with a
//     valid/ready handshake.
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   in_valid/in_ready                decoded instruction handshake
//   in_op, in_rd, in_rs1, in_rs2     opcode and register indices
//   in_imm, in_use_imm, in_wr        immediate, operand-B select, writes rd
//   alu_valid/alu_ready              operand bundle handshake
//   alu_op, alu_a, alu_b, alu_rd,    registered operand bundle
//   alu_wr
//   wb_en, wb_addr, wb_data          ALU result writeback
//   busy                             pending-write bit per register

// One architectural register plus its scoreboard bit (r1..r7 only).
module alu_issue_reg #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wb_hit,
  input  logic [DW-1:0] wb_data,
  input  logic          set_busy,
  output logic [DW-1:0] data,
  output logic          busy
);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data <= '0;
      busy <= 1'b0;
    end else begin
      if (wb_hit) data <= wb_data;
      // When a new writer issues in the same cycle as a writeback, the
      // new writer's set must win.
      if (set_busy)    busy <= 1'b1;
      else if (wb_hit) busy <= 1'b0;
    end
  end
endmodule

module alu_issue #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_op,
  input  logic [2:0]    in_rd,
  input  logic [2:0]    in_rs1,
  input  logic [2:0]    in_rs2,
  input  logic [DW-1:0] in_imm,
  input  logic          in_use_imm,
  input  logic          in_wr,
  output logic          alu_valid,
  input  logic          alu_ready,
  output logic [3:0]    alu_op,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_rd,
  output logic          alu_wr,
  input  logic          wb_en,
  input  logic [2:0]    wb_addr,
  input  logic [DW-1:0] wb_data,
  output logic [7:0]    busy
);
  localparam int NREG = 8;

  logic [NREG-1:0][DW-1:0] rf;
  logic [NREG-1:0]         busy_q;
  logic                    issue;

  // r0 is hard-wired. It has no storage and is never marked busy.
  assign rf[0]     = '0;
  assign busy_q[0] = 1'b0;

  for (genvar g = 1; g < NREG; g++) begin : g_reg
    logic wb_hit, set_busy;
    assign wb_hit   = wb_en && (wb_addr == 3'(g));
    assign set_busy = issue && in_wr && (in_rd == 3'(g));
    alu_issue_reg #(.DW(DW)) u_reg (
      .clk      (clk),
      .rst_n    (rst_n),
      .wb_hit   (wb_hit),
      .wb_data  (wb_data),
      .set_busy (set_busy),
      .data     (rf[g]),
      .busy     (busy_q[g])
    );
  end

  assign busy = busy_q;

  // Source reads. A same-cycle writeback to the source is forwarded.
  // rf[0] is zero, so the nonzero guard only matters for the bypass.
  logic          byp_rs1, byp_rs2;
  logic [DW-1:0] rd_a, rd_b;

  assign byp_rs1 = wb_en && (wb_addr == in_rs1) && (in_rs1 != 3'd0);
  assign byp_rs2 = wb_en && (wb_addr == in_rs2) && (in_rs2 != 3'd0);
  assign rd_a    = byp_rs1 ? wb_data : rf[in_rs1];
  assign rd_b    = in_use_imm ? in_imm : (byp_rs2 ? wb_data : rf[in_rs2]);

  // busy[0] is always 0, so the index-nonzero qualifier is implicit.
  // A writeback resolves a RAW hazard in the same cycle through the bypass.
  // A WAW hazard is not resolved this way: the new writer must not set busy
  // while the older writer's writeback is still clearing it.
  logic haz_rs1, haz_rs2, haz_waw, hazard;

  assign haz_rs1 = busy_q[in_rs1] && !(wb_en && (wb_addr == in_rs1));
  assign haz_rs2 = !in_use_imm && busy_q[in_rs2] && !(wb_en && (wb_addr == in_rs2));
  assign haz_waw = in_wr && busy_q[in_rd];
  assign hazard  = haz_rs1 || haz_rs2 || haz_waw;

  assign in_ready = rst_n && !hazard && (!alu_valid || alu_ready);
  assign issue    = in_valid && in_ready;

  // Output bundle register. EMPTY/FULL tracks whether a bundle is held.
  typedef enum logic {S_EMPTY, S_FULL} state_t;
  state_t state;

  assign alu_valid = (state == S_FULL);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_EMPTY;
      alu_op <= '0;
      alu_a  <= '0;
      alu_b  <= '0;
      alu_rd <= '0;
      alu_wr <= 1'b0;
    end else begin
      // In FULL, an issue is only possible when alu_ready is high, so
      // loading the register here never overwrites an unconsumed bundle.
      if (issue) begin
        alu_op <= in_op;
        alu_a  <= rd_a;
        alu_b  <= rd_b;
        alu_rd <= in_rd;
        alu_wr <= in_wr && (in_rd != 3'd0);
      end
      case (state)
        S_EMPTY: if (issue) state <= S_FULL;
        S_FULL:  if (!issue && alu_ready) state <= S_EMPTY;
        default: state <= S_EMPTY;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_issue.sv
// Randomized scoreboard bench for alu_issue. A behavioural model predicts
// in_ready and busy each cycle and queues expected bundles on issue. A
// separate monitor compares every presented bundle against the queue head.
module tb_alu_issue;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [3:0]    in_op;
  logic [2:0]    in_rd, in_rs1, in_rs2;
  logic [DW-1:0] in_imm;
  logic          in_use_imm, in_wr;
  logic          alu_valid, alu_ready;
  logic [3:0]    alu_op;
  logic [DW-1:0] alu_a, alu_b;
  logic [2:0]    alu_rd;
  logic          alu_wr;
  logic          wb_en;
  logic [2:0]    wb_addr;
  logic [DW-1:0] wb_data;
  logic [7:0]    busy;

  always #5 clk = ~clk;

  alu_issue #(.DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .in_use_imm(in_use_imm), .in_wr(in_wr),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_op(alu_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_rd(alu_rd), .alu_wr(alu_wr),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .busy(busy)
  );

  typedef struct packed {
    logic [3:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [2:0]    rd;
    logic          wr;
  } bundle_t;

  bundle_t       q[$];
  int            errors = 0;
  int            checks = 0;
  logic [DW-1:0] m_reg[8];
  bit            m_busy[8];
  bit            m_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_reg[i]  = '0;
      m_busy[i] = 1'b0;
    end
    m_valid = 1'b0;
    q.delete();
  endtask

  // Value an instruction would see for source register i this cycle.
  function automatic logic [DW-1:0] src_val(input logic [2:0] i);
    if (i == 3'd0) return '0;
    if (wb_en && wb_addr == i) return wb_data;
    return m_reg[i];
  endfunction

  function automatic bit model_hazard();
    bit h = 1'b0;
    if (in_rs1 != 0 && m_busy[in_rs1] && !(wb_en && wb_addr == in_rs1)) h = 1'b1;
    if (!in_use_imm && in_rs2 != 0 && m_busy[in_rs2] && !(wb_en && wb_addr == in_rs2)) h = 1'b1;
    if (in_wr && in_rd != 0 && m_busy[in_rd]) h = 1'b1;
    return h;
  endfunction

  // One clock: check at the falling edge, then advance the model after the rising edge.
  task automatic cycle();
    logic [7:0] mb;
    bit         exp_rdy, issue;
    bundle_t    eb;
    @(negedge clk);
    for (int i = 0; i < 8; i++) mb[i] = m_busy[i];
    chk("busy", busy, mb);
    chk("alu_valid", alu_valid, m_valid);
    exp_rdy = rst_n && !model_hazard() && (!m_valid || alu_ready);
    chk("in_ready", in_ready, exp_rdy);
    issue = in_valid && exp_rdy;
    eb.op = in_op;
    eb.a  = src_val(in_rs1);
    eb.b  = in_use_imm ? in_imm : src_val(in_rs2);
    eb.rd = in_rd;
    eb.wr = in_wr && in_rd != 0;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (issue) q.push_back(eb);
      if (issue) m_valid = 1'b1;
      else if (m_valid && alu_ready) m_valid = 1'b0;
      if (wb_en && wb_addr != 0) m_reg[wb_addr] = wb_data;
      if (wb_en) m_busy[wb_addr] = 1'b0;
      if (issue && in_wr && in_rd != 0) m_busy[in_rd] = 1'b1;
    end
  endtask

  task automatic set_in(input logic v, input logic [3:0] op, input logic [2:0] rd,
                        input logic [2:0] rs1, input logic [2:0] rs2,
                        input logic [DW-1:0] imm, input logic use_imm, input logic wr);
    in_valid = v; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_imm = imm; in_use_imm = use_imm; in_wr = wr;
    #1;
  endtask

  task automatic set_wb(input logic en, input logic [2:0] addr, input logic [DW-1:0] data);
    wb_en = en; wb_addr = addr; wb_data = data;
    #1;
  endtask

  // Monitor: every presented bundle must match the oldest expected one.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && alu_valid === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL bundle: unexpected alu_valid with op=%0h a=%0h", alu_op, alu_a);
        end else begin
          chk("bundle", {8'h0, alu_op, alu_a, alu_b, alu_rd, alu_wr}, {8'h0, q[0]});
          if (alu_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    alu_ready = 1'b1;
    set_in(1, 4'h1, 3'd1, 3'd2, 3'd3, 8'h00, 0, 1);
    set_wb(1, 3'd1, 8'hAA);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_alu_valid", alu_valid, 0);
    chk("rst_busy", busy, 8'h00);
    model_reset();
    rst_n = 1'b1;
    set_wb(0, 0, 0);

    // First issue right after reset; also loads r3 for the next step.
    set_in(1, 4'h0, 3'd0, 3'd0, 3'd0, 8'h00, 1, 0);
    set_wb(1, 3'd3, 8'h5A);
    cycle();
    set_wb(0, 0, 0);

    // Operand read from the register file plus an immediate.
    set_in(1, 4'h2, 3'd4, 3'd3, 3'd0, 8'h11, 1, 1);
    cycle();
    chk("t034_valid", alu_valid, 1);
    chk("t034_a", alu_a, 8'h5A);
    chk("t034_b", alu_b, 8'h11);
    chk("t034_rd", alu_rd, 3'd4);
    chk("t034_busy4", busy[4], 1);

    // RAW stall on r4, released by its writeback through the bypass.
    set_in(1, 4'h3, 3'd6, 3'd4, 3'd0, 8'h01, 1, 0);
    chk("t035_stall", in_ready, 0);
    cycle();
    cycle();
    set_wb(1, 3'd4, 8'h77);
    chk("t035_release", in_ready, 1);
    cycle();
    set_wb(0, 0, 0);
    chk("t035_bypass", alu_a, 8'h77);

    // Backpressure: hold for 3 cycles, then consume and issue with no bubble.
    alu_ready = 1'b0;
    set_in(1, 4'h5, 3'd2, 3'd1, 3'd2, 8'h00, 0, 1);
    for (int i = 0; i < 3; i++) begin
      chk("t036_hold_ready", in_ready, 0);
      cycle();
      chk("t036_hold_a", alu_a, 8'h77);
    end
    alu_ready = 1'b1;
    cycle();
    chk("t036_next_valid", alu_valid, 1);
    chk("t036_next_rd", alu_rd, 3'd2);

    // r0: never busy, writes ignored, reads as zero.
    set_wb(1, 3'd2, 8'h33);
    set_in(1, 4'h0, 3'd0, 3'd1, 3'd1, 8'h00, 1, 1);
    cycle();
    chk("t037_busy", busy, 8'h00);
    chk("t037_wr", alu_wr, 0);
    set_wb(1, 3'd0, 8'hFF);
    set_in(0, 4'h0, 3'd0, 3'd0, 3'd0, 8'h00, 1, 0);
    cycle();
    set_wb(0, 0, 0);
    set_in(1, 4'h4, 3'd1, 3'd0, 3'd0, 8'h00, 1, 0);
    cycle();
    chk("t037_r0", alu_a, 8'h00);

    // WAW: same-cycle writeback of r5 does not release a new r5 writer.
    set_in(1, 4'h6, 3'd5, 3'd0, 3'd0, 8'h00, 1, 1);
    cycle();
    set_wb(1, 3'd5, 8'h12);
    chk("t038_stall", in_ready, 0);
    cycle();
    set_wb(0, 0, 0);
    chk("t038_accept", in_ready, 1);
    cycle();

    // Reset while a bundle is held and r4/r5 are pending.
    set_in(1, 4'h7, 3'd4, 3'd0, 3'd0, 8'h00, 1, 1);
    set_wb(1, 3'd5, 8'h00);
    cycle();
    set_wb(0, 0, 0);
    set_in(1, 4'h7, 3'd5, 3'd0, 3'd0, 8'h00, 1, 1);
    cycle();
    alu_ready = 1'b0;
    set_in(0, 4'h0, 3'd0, 3'd0, 3'd0, 8'h00, 1, 0);
    cycle();
    chk("t039_busy_pre", busy, 8'h30);
    rst_n = 1'b0;
    set_in(1, 4'h1, 3'd6, 3'd0, 3'd0, 8'h00, 1, 1);
    set_wb(1, 3'd2, 8'h44);
    cycle();
    rst_n = 1'b1;
    set_wb(0, 0, 0);
    alu_ready = 1'b1;
    chk("t039_valid", alu_valid, 0);
    chk("t039_busy", busy, 8'h00);
    set_in(1, 4'h1, 3'd0, 3'd3, 3'd2, 8'h00, 0, 0);
    cycle();
    chk("t039_r3", alu_a, 8'h00);
    chk("t039_r2", alu_b, 8'h00);

    // Random traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      alu_ready = ($urandom_range(0, 3) != 0);
      set_in($urandom_range(0, 3) != 0, 4'($urandom), 3'($urandom), 3'($urandom),
             3'($urandom), 8'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
      set_wb($urandom_range(0, 2) == 0, 3'($urandom), 8'($urandom));
      cycle();
    end

    // Drain the output bundle.
    rst_n = 1'b1;
    alu_ready = 1'b1;
    set_in(0, 4'h0, 3'd0, 3'd0, 3'd0, 8'h00, 1, 0);
    set_wb(0, 0, 0);
    repeat (3) cycle();
    chk("drain_queue", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
